// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory responder.
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_DONE
  } mem_state_e;

  localparam int          MEM_LATENCY_DEFAULT = 5;
  localparam logic [15:0] PC_RESET            = 16'h3000;

endpackage

// File: rtl/lc3b_mem_port_fsm.sv
// Per-port access sequencer: accepts a request, counts out the access latency,
// then presents a one-cycle done strobe with the address captured at acceptance.
module lc3b_mem_port_fsm
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              accept,
  output logic              done,
  output logic [ADDR_W-1:0] cap_addr
);

  localparam int CNT_W = 4;

  mem_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) cap_addr <= addr;
  end

  // cnt is tested before decrementing, so DONE lands exactly LATENCY cycles after acceptance
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    done    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_n   = CNT_W'(LATENCY - 1);
          state_n = (LATENCY > 1) ? MEM_BUSY : MEM_DONE;
        end
      end
      MEM_BUSY: begin
        if (!req) begin
          state_n = MEM_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_n = MEM_DONE;
        end
      end
      MEM_DONE: begin
        done    = 1'b1;
        state_n = MEM_IDLE;
      end
      default: state_n = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Two-port word memory for the LC-3b pipeline: fixed-latency instruction reads
// and data reads with byte-lane writes committed at the end of the DONE cycle.
module lc3b_mem_responder
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_ready,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_we_low,
  input  logic        d_we_high,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready
);

  logic [15:0] mem [2**ADDR_W];

  logic              i_accept, i_done, d_accept, d_done;
  logic [ADDR_W-1:0] i_cap, d_cap;
  logic              we_low_q, we_high_q;
  logic [15:0]       wdata_q;
  logic              unused_addr;

  // byte bit 0 and any bits above the word address are don't-care (aliasing)
  assign unused_addr = ^{i_addr, d_addr, i_accept};

  lc3b_mem_port_fsm #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) u_i_port (
    .clk      (clk),
    .rst      (rst),
    .req      (i_req),
    .addr     (i_addr[ADDR_W:1]),
    .accept   (i_accept),
    .done     (i_done),
    .cap_addr (i_cap)
  );

  lc3b_mem_port_fsm #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) u_d_port (
    .clk      (clk),
    .rst      (rst),
    .req      (d_req),
    .addr     (d_addr[ADDR_W:1]),
    .accept   (d_accept),
    .done     (d_done),
    .cap_addr (d_cap)
  );

  always_ff @(posedge clk) begin
    if (d_accept) begin
      we_low_q  <= d_we_low;
      we_high_q <= d_we_high;
      wdata_q   <= d_wdata;
    end
  end

  // Commit at the DONE edge so a same-cycle i-port read still sees the old word
  always_ff @(posedge clk) begin
    if (!rst && d_done) begin
      if (we_low_q)  mem[d_cap][7:0]  <= wdata_q[7:0];
      if (we_high_q) mem[d_cap][15:8] <= wdata_q[15:8];
    end
  end

  assign i_ready = i_done;
  assign d_ready = d_done;
  assign i_data  = i_done ? mem[i_cap] : 16'h0000;
  assign d_rdata = d_done ? mem[d_cap] : 16'h0000;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench: one LATENCY=5 responder and one LATENCY=1 responder with a
// narrow address space; a negedge monitor checks every ready strobe against a queue.
module tb_lc3b_mem_responder;
  import lc3b_mem_pkg::*;

  localparam int L0 = 5;
  localparam int L1 = 1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req0, d_req0, d_we_low0, d_we_high0;
  logic [15:0] i_addr0, d_addr0, d_wdata0, i_data0, d_rdata0;
  logic        i_ready0, d_ready0;
  logic        i_req1, d_req1, d_we_low1, d_we_high1;
  logic [15:0] i_addr1, d_addr1, d_wdata1, i_data1, d_rdata1;
  logic        i_ready1, d_ready1;

  lc3b_mem_responder #(.ADDR_W(15), .LATENCY(L0)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req0), .i_addr(i_addr0), .i_data(i_data0), .i_ready(i_ready0),
    .d_req(d_req0), .d_addr(d_addr0), .d_we_low(d_we_low0), .d_we_high(d_we_high0),
    .d_wdata(d_wdata0), .d_rdata(d_rdata0), .d_ready(d_ready0)
  );

  lc3b_mem_responder #(.ADDR_W(4), .LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_data(i_data1), .i_ready(i_ready1),
    .d_req(d_req1), .d_addr(d_addr1), .d_we_low(d_we_low1), .d_we_high(d_we_high1),
    .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_ready(d_ready1)
  );

  exp_t q_i0[$], q_d0[$], q_i1[$], q_d1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Ports: 0 = i/dut, 1 = d/dut, 2 = i/dut1, 3 = d/dut1
  function automatic logic get_rdy(input int p);
    case (p)
      0:       return i_ready0;
      1:       return d_ready0;
      2:       return i_ready1;
      default: return d_ready1;
    endcase
  endfunction

  function automatic int get_lat(input int p);
    return (p < 2) ? L0 : L1;
  endfunction

  task automatic push(input int p, input exp_t e);
    case (p)
      0:       q_i0.push_back(e);
      1:       q_d0.push_back(e);
      2:       q_i1.push_back(e);
      default: q_d1.push_back(e);
    endcase
  endtask

  task automatic set_req(input int p, input logic r, input logic [15:0] a,
                         input logic wl, input logic wh, input logic [15:0] wd);
    case (p)
      0: begin i_req0 = r; i_addr0 = a; end
      1: begin d_req0 = r; d_addr0 = a; d_we_low0 = wl; d_we_high0 = wh; d_wdata0 = wd; end
      2: begin i_req1 = r; i_addr1 = a; end
      default: begin d_req1 = r; d_addr1 = a; d_we_low1 = wl; d_we_high1 = wh; d_wdata1 = wd; end
    endcase
  endtask

  task automatic mon(input int p, input string nm, input logic rdy, input logic [15:0] dat);
    exp_t e;
    bit   have = 1'b0;
    checks++;
    if (!rdy) begin
      if (dat !== 16'h0000) begin
        errors++;
        $display("FAIL %s idle data: got %h, want 0000", nm, dat);
      end
      return;
    end
    case (p)
      0: if (q_i0.size() > 0) begin e = q_i0.pop_front(); have = 1'b1; end
      1: if (q_d0.size() > 0) begin e = q_d0.pop_front(); have = 1'b1; end
      2: if (q_i1.size() > 0) begin e = q_i1.pop_front(); have = 1'b1; end
      default: if (q_d1.size() > 0) begin e = q_d1.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected ready at cycle %0d, want no ready", nm, cyc);
    end else begin
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s ready cycle: got %0d, want %0d", nm, cyc, e.cyc);
      end
      if (e.chk) begin
        checks++;
        if (dat !== e.data) begin
          errors++;
          $display("FAIL %s data: got %h, want %h", nm, dat, e.data);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, "i_port", i_ready0, i_data0);
    mon(1, "d_port", d_ready0, d_rdata0);
    mon(2, "i_port_lat1", i_ready1, i_data1);
    mon(3, "d_port_lat1", d_ready1, d_rdata1);
  end

  // One access: request held until the ready strobe, dropped in the DONE cycle.
  task automatic access(input int p, input logic [15:0] a, input logic wl, input logic wh,
                        input logic [15:0] wd, input logic [15:0] exp, input bit c);
    exp_t e;
    bit   seen = 1'b0;
    @(negedge clk);
    e.data = exp;
    e.cyc  = cyc + get_lat(p);
    e.chk  = c;
    push(p, e);
    set_req(p, 1'b1, a, wl, wh, wd);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_rdy(p)) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("ready_seen_p%0d", p), int'(seen), 1);
    set_req(p, 1'b0, a, 1'b0, 1'b0, wd);
  endtask

  task automatic back_to_back(input int p, input logic [15:0] a, input logic [15:0] exp,
                              input int n);
    exp_t e;
    int   got = 0;
    int   lat = get_lat(p);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      e.data = exp;
      e.cyc  = cyc + lat + k * (lat + 1);
      e.chk  = 1'b1;
      push(p, e);
    end
    set_req(p, 1'b1, a, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 20 * n; k++) begin
      @(negedge clk);
      if (get_rdy(p)) got++;
      if (got == n) break;
    end
    chk($sformatf("b2b_pulses_p%0d", p), got, n);
    set_req(p, 1'b0, a, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 4; p++) set_req(p, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_i_ready", int'(i_ready0), 0);
    chk("reset_d_ready", int'(d_ready0), 0);
    chk("reset_i_data", int'(i_data0), 0);
    chk("reset_d_rdata", int'(d_rdata0), 0);
    rst = 1'b0;

    // preload through the data port (rdata of the first write is unknown)
    access(1, PC_RESET, 1'b1, 1'b1, 16'hE002, 16'h0000, 1'b0);
    access(1, 16'h4000, 1'b1, 1'b1, 16'h5566, 16'h0000, 1'b0);
    access(1, 16'h4002, 1'b1, 1'b1, 16'h7777, 16'h0000, 1'b0);

    // fetch read, odd byte address reads the same word
    access(0, PC_RESET, 1'b0, 1'b0, 16'h0000, 16'hE002, 1'b1);
    access(0, 16'h3001, 1'b0, 1'b0, 16'h0000, 16'hE002, 1'b1);

    // byte-lane writes
    access(1, 16'h4000, 1'b1, 1'b0, 16'hAB12, 16'h5566, 1'b1);
    access(1, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'h5512, 1'b1);
    access(1, 16'h4000, 1'b0, 1'b1, 16'hCD00, 16'h5512, 1'b1);
    access(1, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'hCD12, 1'b1);
    access(0, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'hCD12, 1'b1);

    // abort a write in BUSY cycle 2
    @(negedge clk);
    set_req(1, 1'b1, 16'h4002, 1'b1, 1'b1, 16'hFFFF);
    repeat (2) @(negedge clk);
    set_req(1, 1'b0, 16'h4002, 1'b0, 1'b0, 16'h0000);
    repeat (8) @(negedge clk);
    access(1, 16'h4002, 1'b0, 1'b0, 16'h0000, 16'h7777, 1'b1);

    // reset during i-port BUSY
    @(negedge clk);
    set_req(0, 1'b1, PC_RESET, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, PC_RESET, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("midreset_i_ready", int'(i_ready0), 0);
    chk("midreset_i_data", int'(i_data0), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    access(0, PC_RESET, 1'b0, 1'b0, 16'h0000, 16'hE002, 1'b1);

    // same-cycle conflict on one word
    fork
      access(0, PC_RESET, 1'b0, 1'b0, 16'h0000, 16'hE002, 1'b1);
      access(1, PC_RESET, 1'b1, 1'b1, 16'h1234, 16'hE002, 1'b1);
    join
    access(0, PC_RESET, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1);

    // back-to-back at LATENCY=5
    back_to_back(0, PC_RESET, 16'h1234, 3);

    // LATENCY=1 unit with ADDR_W=4: aliasing and back-to-back every 2 cycles
    access(3, 16'h0002, 1'b1, 1'b1, 16'hA5A5, 16'h0000, 1'b0);
    access(2, 16'h0022, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1'b1);
    access(3, 16'h0002, 1'b1, 1'b0, 16'h003C, 16'hA5A5, 1'b1);
    access(2, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'hA53C, 1'b1);
    back_to_back(2, 16'h0002, 16'hA53C, 3);

    repeat (5) @(negedge clk);
    chk("q_i0_drained", q_i0.size(), 0);
    chk("q_d0_drained", q_d0.size(), 0);
    chk("q_i1_drained", q_i1.size(), 0);
    chk("q_d1_drained", q_d1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
